// File: rtl/ifid_queue_if.sv
// ---------------------------------------------------------------------------
// ifid_queue_if
//
// Purpose: bundles the fetch-side push port, the decode-side pop port, the
// memory-stage flush and the status outputs of the IF/ID instruction queue.
//
// Ports (signals carried):
//   in_valid  / in_instr / in_pc   fetch presents an instruction and its PC
//   in_ready                       queue can take a push this cycle
//   flush                          branch redirect, discard every entry
//   out_valid / out_instr / out_pc / out_npc
//                                  oldest entry presented to decode
//   out_ready                      decode takes the head this cycle
//   halt                           sticky, a zero instruction was popped
//   count                          number of occupied entries
//
// Modports:
//   slave  - the queue itself
//   master - the surrounding pipeline (fetch, decode, memory stage)
// ---------------------------------------------------------------------------
interface ifid_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [31:0]      in_instr;
  logic [63:0]      in_pc;
  logic             in_ready;

  logic             flush;

  logic             out_valid;
  logic [31:0]      out_instr;
  logic [63:0]      out_pc;
  logic [63:0]      out_npc;
  logic             out_ready;

  logic             halt;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_npc, halt, count
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_npc, halt, count
  );
endinterface

// File: rtl/ifid_queue.sv
// ---------------------------------------------------------------------------
// ifid_queue
//
// Purpose: in-order instruction buffer between fetch and decode. Holds up to
// DEPTH {instr, pc} entries in a circular buffer, presents the oldest one to
// decode with a valid/ready handshake, drops everything on a branch redirect
// and raises a sticky halt once the all-zero instruction is handed to decode.
//
// Parameters:
//   DEPTH  number of entries, power of two, at least 2
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-low; clears pointers, count, halt, storage
//   bus    ifid_queue_if.slave (see the interface file for the signal list)
// ---------------------------------------------------------------------------
module ifid_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  ifid_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0]      HALT_INSTR = 32'h0000_0000;

  // Circular buffer storage, kept as two parallel arrays.
  logic [31:0] instr_mem [DEPTH];
  logic [63:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             halt;

  logic [CNT_W-1:0] count_next;
  logic             halt_next;

  logic             full;
  logic             empty;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic [31:0]      head_instr;
  logic [63:0]      head_pc;
  logic             halt_hit;

  // -------------------------------------------------------------------------
  // Handshake status. in_ready and out_valid come from registered state only,
  // so a full queue refuses a push even if decode pops in the same cycle.
  // -------------------------------------------------------------------------
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full && !halt;
  assign out_valid = !empty && !halt;

  assign push = bus.in_valid && in_ready;
  assign pop  = out_valid && bus.out_ready;

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  // A zero instruction leaving the queue stops the pipeline; a same-cycle
  // flush voids the pop and therefore also the halt.
  assign halt_hit = pop && (head_instr == HALT_INSTR) && !bus.flush;

  // -------------------------------------------------------------------------
  // Next-state for count and halt. Flush wins over everything else.
  // -------------------------------------------------------------------------
  always_comb begin
    count_next = count;
    halt_next  = halt;
    if (bus.flush) begin
      count_next = '0;
      halt_next  = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
      if (halt_hit) begin
        halt_next = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pointer, count and halt registers. Pointers wrap naturally because DEPTH
  // is a power of two.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      halt   <= 1'b0;
    end else begin
      count <= count_next;
      halt  <= halt_next;
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage. Cleared only by reset; a flush leaves old contents in place since
  // the pointers alone decide what is live. A push that coincides with a flush
  // is dropped and never written.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push && !bus.flush) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_pc;
    end
  end

  // -------------------------------------------------------------------------
  // Decode-side data. Masked to a NOP at PC 0 whenever nothing is presented so
  // decode never sees stale slots. out_npc wraps modulo 2^64.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.out_instr = NOP_INSTR;
    bus.out_pc    = '0;
    bus.out_npc   = '0;
    if (out_valid) begin
      bus.out_instr = head_instr;
      bus.out_pc    = head_pc;
      bus.out_npc   = head_pc + 64'd4;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.halt      = halt;
  assign bus.count     = count;

endmodule

// File: tb/tb_ifid_queue.sv
// ---------------------------------------------------------------------------
// tb_ifid_queue
//
// Purpose: directed self-checking bench for ifid_queue with DEPTH=4. Inputs
// change 1ns after the rising edge; outputs are sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_ifid_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  int checks;
  int errors;

  ifid_queue_if #(.DEPTH(DEPTH)) bus ();

  ifid_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the fetch port for the following edge.
  task automatic apply_stimulus(input logic valid, input logic [63:0] pc,
                                input logic [31:0] instr);
    bus.in_valid = valid;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  // Check every output against its reset value.
  task automatic check_reset_values(input string tag);
    check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check_output({tag, "_out_instr"}, 64'(bus.out_instr), 64'h13);
    check_output({tag, "_out_pc"},    bus.out_pc,         64'd0);
    check_output({tag, "_out_npc"},   bus.out_npc,        64'd0);
    check_output({tag, "_halt"},      64'(bus.halt),      64'd0);
    check_output({tag, "_count"},     64'(bus.count),     64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(1'b0, 64'd0, 32'd0);

    // Reset state.
    #1;
    check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic flow: push, present after one edge, pop the next edge.
    apply_stimulus(1'b1, 64'h1000, 32'h0050_0093);
    bus.out_ready = 1'b1;
    check_output("basic_pre_valid", 64'(bus.out_valid), 64'd0);
    check_output("basic_pre_instr", 64'(bus.out_instr), 64'h13);
    tick();
    apply_stimulus(1'b0, 64'd0, 32'd0);
    check_output("basic_valid", 64'(bus.out_valid), 64'd1);
    check_output("basic_pc",    bus.out_pc,          64'h1000);
    check_output("basic_npc",   bus.out_npc,         64'h1004);
    check_output("basic_instr", 64'(bus.out_instr),  64'h0050_0093);
    check_output("basic_count", 64'(bus.count),      64'd1);
    tick();
    check_output("basic_popped_count", 64'(bus.count),     64'd0);
    check_output("basic_popped_valid", 64'(bus.out_valid), 64'd0);

    // Fill and wrap: pointers start at 1, so the fill crosses the wrap.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 64'(i * 4), 32'h100 + 32'(i));
      tick();
    end
    check_output("fill_count",    64'(bus.count),    64'd4);
    check_output("fill_in_ready", 64'(bus.in_ready), 64'd0);
    apply_stimulus(1'b1, 64'h10, 32'h104);
    tick();
    check_output("fill_refused_count", 64'(bus.count), 64'd4);
    check_output("fill_head_pc",       bus.out_pc,     64'h0);
    // Full queue with decode ready: the push is still refused this cycle.
    bus.out_ready = 1'b1;
    check_output("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check_output("full_pop_count",    64'(bus.count),    64'd3);
    check_output("full_pop_head_pc",  bus.out_pc,        64'h4);
    check_output("full_pop_in_ready2", 64'(bus.in_ready), 64'd1);
    tick();
    apply_stimulus(1'b0, 64'd0, 32'd0);
    check_output("wrap_pushpop_count", 64'(bus.count), 64'd3);
    check_output("wrap_head_pc0", bus.out_pc, 64'h8);
    tick();
    check_output("wrap_head_pc1", bus.out_pc, 64'hc);
    tick();
    check_output("wrap_head_pc2",    bus.out_pc,         64'h10);
    check_output("wrap_head_instr2", 64'(bus.out_instr), 64'h104);
    tick();
    check_output("wrap_drained_count", 64'(bus.count), 64'd0);

    // Simultaneous push and pop at count=2.
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 64'h20, 32'h120);
    tick();
    apply_stimulus(1'b1, 64'h24, 32'h124);
    tick();
    check_output("sim_pre_count", 64'(bus.count), 64'd2);
    apply_stimulus(1'b1, 64'h28, 32'h128);
    bus.out_ready = 1'b1;
    check_output("sim_head0", bus.out_pc, 64'h20);
    tick();
    apply_stimulus(1'b0, 64'd0, 32'd0);
    check_output("sim_count", 64'(bus.count), 64'd2);
    check_output("sim_head1", bus.out_pc,     64'h24);
    tick();
    check_output("sim_head2",  bus.out_pc,     64'h28);
    check_output("sim_count2", 64'(bus.count), 64'd1);
    tick();
    check_output("sim_drained", 64'(bus.count), 64'd0);

    // Flush with a concurrent push and pop.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 64'h30 + 64'(i * 4), 32'h130 + 32'(i));
      tick();
    end
    check_output("flush_pre_count", 64'(bus.count), 64'd3);
    apply_stimulus(1'b1, 64'h3c, 32'h13c);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(1'b0, 64'd0, 32'd0);
    check_output("flush_count",    64'(bus.count),     64'd0);
    check_output("flush_valid",    64'(bus.out_valid), 64'd0);
    check_output("flush_in_ready", 64'(bus.in_ready),  64'd1);
    apply_stimulus(1'b1, 64'h40, 32'h140);
    tick();
    apply_stimulus(1'b0, 64'd0, 32'd0);
    check_output("flush_next_valid", 64'(bus.out_valid), 64'd1);
    check_output("flush_next_pc",    bus.out_pc,         64'h40);
    check_output("flush_next_count", 64'(bus.count),     64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_output("flush_next_drained", 64'(bus.count), 64'd0);

    // Halt on popping the zero instruction.
    apply_stimulus(1'b1, 64'h50, 32'h0000_0013);
    tick();
    apply_stimulus(1'b1, 64'h54, 32'h0000_0000);
    tick();
    apply_stimulus(1'b1, 64'h58, 32'h0010_0093);
    tick();
    apply_stimulus(1'b0, 64'd0, 32'd0);
    bus.out_ready = 1'b1;
    check_output("halt_head0", 64'(bus.out_instr), 64'h13);
    tick();
    check_output("halt_head1",   64'(bus.out_instr), 64'h0);
    check_output("halt_not_yet", 64'(bus.halt),      64'd0);
    tick();
    check_output("halt_set",      64'(bus.halt),      64'd1);
    check_output("halt_valid",    64'(bus.out_valid), 64'd0);
    check_output("halt_in_ready", 64'(bus.in_ready),  64'd0);
    check_output("halt_count",    64'(bus.count),     64'd1);
    check_output("halt_masked",   64'(bus.out_instr), 64'h13);
    tick();
    check_output("halt_sticky",       64'(bus.halt),  64'd1);
    check_output("halt_sticky_count", 64'(bus.count), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    check_output("halt_flush_halt",     64'(bus.halt),     64'd0);
    check_output("halt_flush_count",    64'(bus.count),    64'd0);
    check_output("halt_flush_in_ready", 64'(bus.in_ready), 64'd1);

    // PC+4 wraps to zero at the top of the address space.
    apply_stimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h200);
    tick();
    check_output("wrap_npc", bus.out_npc, 64'd0);
    check_output("wrap_pc",  bus.out_pc,  64'hFFFF_FFFF_FFFF_FFFC);
    apply_stimulus(1'b1, 64'h60, 32'h160);
    tick();
    apply_stimulus(1'b0, 64'd0, 32'd0);
    check_output("async_pre_count", 64'(bus.count), 64'd2);

    // Asynchronous reset between edges takes effect before the next edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check_output("post_rst_count", 64'(bus.count),     64'd0);
    check_output("post_rst_valid", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Instruction buffer between the fetch stage and the decode stage. It accepts one fetched instruction and its PC per cycle from fetch and holds up to DEPTH entries in order. It presents the oldest entry to decode with a valid/ready handshake and discards everything on a branch redirect from the memory stage. It also detects the all-zero halt instruction at the decode boundary.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- in_valid  in  1  fetch has a valid instruction this cycle (fetch data_ack)
- in_instr  in  32  fetched instruction word
- in_pc  in  64  PC of in_instr
- in_ready  out  1  queue can accept a push this cycle
- flush  in  1  branch redirect from memory stage; discard all entries
- out_valid  out  1  head entry is presented to decode
- out_instr  out  32  head instruction
- out_pc  out  64  head PC
- out_npc  out  64  head PC + 4
- out_ready  in  1  decode accepts the head this cycle
- halt  out  1  sticky; a zero instruction has been popped
- count  out  clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage is a circular buffer of {instr[31:0], pc[63:0]} with head (rd_ptr), tail (wr_ptr) and count. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- push = in_valid && in_ready. Write to slot wr_ptr, then wr_ptr+1.
- pop = out_valid && out_ready. Advance rd_ptr+1.
- in_ready = (count != DEPTH) && !halt. A full queue does not accept a push even when a pop occurs in the same cycle. There is no pass-through.
- out_valid = (count != 0) && !halt.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- The data outputs are combinational from slot rd_ptr, masked when out_valid=0:
  - out_instr = 32'h00000013 (NOP)
  - out_pc = 0
  - out_npc = 0
- When valid, out_npc = out_pc + 64'd4, modulo 2^64. 0xFFFF_FFFF_FFFF_FFFC yields 0.
- Halt: when a pop occurs with out_instr == 32'h0, halt is set at that edge. While halt=1, out_valid=0 and in_ready=0.
- Flush has priority over push, pop and halt set in the same cycle. At the edge:
  - count, rd_ptr and wr_ptr are set to 0.
  - halt is cleared.
  - A concurrent push is dropped.
  - A concurrent pop is void; the zero-instruction halt check is suppressed.
- Storage contents are not cleared by flush. Only pointers and count matter.
- Reset low: count, rd_ptr, wr_ptr and halt go to 0 and storage goes to 0, asynchronously. Output values during and after reset are out_valid=0, in_ready=1, out_instr=0x00000013, out_pc=0, out_npc=0, halt=0, count=0.
- Reset asserted mid-transfer aborts the transfer. No partial entry survives.

## Timing
- Push-to-present latency is 1 cycle: a push at edge N gives out_valid=1 after edge N, so decode can pop at edge N+1.
- Sustained throughput is one push and one pop per cycle when count is between 1 and DEPTH-1.
- in_ready, out_valid and count are functions of registered state only. There is no combinational path from in_valid or out_ready to any output.
- The data outputs depend combinationally on rd_ptr and storage only.
- Flush asserted at edge N gives out_valid=0 and count=0 after N. A push at N+1 is presented after N+1.
- Halt set at edge N gives out_valid=0 and in_ready=0 after N.

## Test plan
- Reset and basic flow:
  - Stimulus: reset low, then release; push pc=0x1000 instr=0x00500093, out_ready=1.
  - Response: before the push, out_valid=0 and out_instr=0x13. After the push, out_valid=1, out_pc=0x1000 and out_npc=0x1004; it pops the next cycle and count returns to 0.
- Fill and wrap:
  - Stimulus: out_ready=0; push 5 entries pc=0x0,0x4,...,0x10; then out_ready=1 with continued pushes.
  - Response: after 4 pushes, in_ready=0 and count=4. The 5th push is refused (fetch holds it). Pops emerge in PC order 0x0..0x10 with no loss across the pointer wrap.
- Simultaneous push and pop at count=2: count stays 2 and ordering is preserved. At count=4 with out_ready=1, a push is refused that cycle.
- Flush:
  - Stimulus: count=3; flush=1 with in_valid=1 and out_ready=1 in the same cycle.
  - Response: next cycle count=0 and out_valid=0. The pushed entry is absent and the next push is the first to appear.
- Halt:
  - Stimulus: push 0x00000013, then 0x00000000, then 0x00100093.
  - Response: after the zero instruction is popped, halt=1, out_valid=0 and in_ready=0, with 0x00100093 still held (count=1). A following flush clears halt and sets count to 0.
- Wrap arithmetic and async reset:
  - Stimulus: push pc=0xFFFF_FFFF_FFFF_FFFC, then drive reset low between clock edges with count=2.
  - Response: out_npc=0 for that entry. All outputs take their reset values immediately, before the next edge.
